agc_gain_ctrl: RTL and testbench

- Closed-loop gain controller for the AGC path.
- Consumes averaged power samples from the power-averaging datapath and compares each against a programmable target with a deadband.
- Steps a registered gain word up or down (coarse or fine), waits for the moving average to refill after each change, and reports lock and saturation.
- Gain word drives the front-end scaler/attenuator.

---
 rtl/agc_gain_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_agc_gain_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/agc_gain_ctrl.sv
// ============================================================================
// agc_gain_ctrl
// ----------------------------------------------------------------------------
// Closed-loop gain controller for the AGC path. Each averaged power sample is
// compared against a target with a +/- tol deadband. Outside the band the
// gain word is stepped (coarse or fine) toward the target, clamped to
// GAIN_MIN..GAIN_MAX, and the loop then waits SETTLE_CYCLES clocks for the
// moving average to refill before accepting another measurement.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   i_en                loop enable; low returns the loop to IDLE
//   i_gain_load         load i_gain_load_val (honoured only in IDLE, i_en=0)
//   i_gain_load_val     manual gain value, clamped before use
//   i_pow_in            averaged power sample (unsigned)
//   i_pow_valid         qualifier for i_pow_in
//   i_target, i_tol     power setpoint and deadband half-width (unsigned)
//   o_gain_out          registered gain word to the front-end scaler
//   o_gain_update       one-cycle pulse on every o_gain_out change
//   o_locked            LOCK_COUNT consecutive in-band measurements seen
//   o_sat_hi, o_sat_lo  last out-of-band step was clamped at max / min
//   o_state_dbg         IDLE=0, MEASURE=1, ADJUST=2, SETTLE=3
// ============================================================================
module agc_gain_ctrl #(
    parameter int POW_WIDTH     = 16,
    parameter int GAIN_WIDTH    = 8,
    parameter int GAIN_INIT     = 128,
    parameter int GAIN_MIN      = 0,
    parameter int GAIN_MAX      = 255,
    parameter int STEP_COARSE   = 8,
    parameter int STEP_FINE     = 1,
    parameter int SETTLE_CYCLES = 64,
    parameter int LOCK_COUNT    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic                  i_gain_load,
    input  logic [GAIN_WIDTH-1:0] i_gain_load_val,
    input  logic [POW_WIDTH-1:0]  i_pow_in,
    input  logic                  i_pow_valid,
    input  logic [POW_WIDTH-1:0]  i_target,
    input  logic [POW_WIDTH-1:0]  i_tol,
    output logic [GAIN_WIDTH-1:0] o_gain_out,
    output logic                  o_gain_update,
    output logic                  o_locked,
    output logic                  o_sat_hi,
    output logic                  o_sat_lo,
    output logic [1:0]            o_state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_ADJUST  = 2'd2,
        S_SETTLE  = 2'd3
    } state_t;

    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int LOCK_W = $clog2(LOCK_COUNT + 1);

    localparam logic [GAIN_WIDTH:0] L_GMIN   = (GAIN_WIDTH+1)'(GAIN_MIN);
    localparam logic [GAIN_WIDTH:0] L_GMAX   = (GAIN_WIDTH+1)'(GAIN_MAX);
    localparam logic [GAIN_WIDTH:0] L_STEP_C = (GAIN_WIDTH+1)'(STEP_COARSE);
    localparam logic [GAIN_WIDTH:0] L_STEP_F = (GAIN_WIDTH+1)'(STEP_FINE);
    localparam logic [SET_W-1:0]    L_SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [LOCK_W-1:0]   L_LOCK     = LOCK_W'(LOCK_COUNT);

    // Saturate a one-bit-wider gain candidate into GAIN_MIN..GAIN_MAX.
    // 'under' flags a borrow out of a down-step, which wraps to a large value.
    function automatic logic [GAIN_WIDTH-1:0] clamp_gain(
        input logic [GAIN_WIDTH:0] v,
        input logic                under
    );
        logic [GAIN_WIDTH:0] c;
        if (under || (v < L_GMIN)) begin
            c = L_GMIN;
        end else if (v > L_GMAX) begin
            c = L_GMAX;
        end else begin
            c = v;
        end
        return GAIN_WIDTH'(c);
    endfunction

    state_t                  r_state, w_state_nxt;
    logic [GAIN_WIDTH-1:0]   r_gain, w_gain_nxt, w_gain_adj;
    logic                    r_upd;
    logic                    r_locked, w_locked_nxt;
    logic                    r_sat_hi, w_sat_hi_nxt;
    logic                    r_sat_lo, w_sat_lo_nxt;
    logic [SET_W-1:0]        r_settle_cnt, w_settle_nxt;
    logic [LOCK_W-1:0]       r_lock_cnt, w_lock_nxt;
    logic [POW_WIDTH-1:0]    r_pow;

    logic signed [POW_WIDTH:0] w_err;
    logic [POW_WIDTH:0]        w_mag;
    logic                      w_in_band, w_coarse, w_up;
    logic                      w_clamp_hi, w_clamp_lo;
    logic [GAIN_WIDTH:0]       w_step, w_sum, w_dif;

    // Error is evaluated against the live target/tol so setpoint changes
    // apply at the next ADJUST without disturbing the lock counter.
    assign w_err     = $signed({1'b0, r_pow}) - $signed({1'b0, i_target});
    assign w_mag     = w_err[POW_WIDTH] ? $unsigned(-w_err) : $unsigned(w_err);
    assign w_in_band = (w_mag <= {1'b0, i_tol});
    // Two extra bits so 4*tol cannot overflow; tol=0 always yields coarse.
    assign w_coarse  = ({1'b0, w_mag} >= {i_tol, 2'b00});
    // Power below target -> raise gain.
    assign w_up      = w_err[POW_WIDTH];
    assign w_step    = w_coarse ? L_STEP_C : L_STEP_F;
    assign w_sum     = {1'b0, r_gain} + w_step;
    assign w_dif     = {1'b0, r_gain} - w_step;

    assign w_clamp_hi = w_up && (w_sum > L_GMAX);
    assign w_clamp_lo = !w_up && (w_dif[GAIN_WIDTH] || (w_dif < L_GMIN));
    assign w_gain_adj = w_up ? clamp_gain(w_sum, 1'b0)
                             : clamp_gain(w_dif, w_dif[GAIN_WIDTH]);

    always_comb begin
        w_state_nxt  = r_state;
        w_gain_nxt   = r_gain;
        w_locked_nxt = r_locked;
        w_sat_hi_nxt = r_sat_hi;
        w_sat_lo_nxt = r_sat_lo;
        w_settle_nxt = r_settle_cnt;
        w_lock_nxt   = r_lock_cnt;

        case (r_state)
            S_IDLE: begin
                if (i_en) begin
                    w_state_nxt = S_MEASURE;
                end else if (i_gain_load) begin
                    w_gain_nxt = clamp_gain({1'b0, i_gain_load_val}, 1'b0);
                end
            end
            S_MEASURE: begin
                if (i_pow_valid) begin
                    w_state_nxt = S_ADJUST;
                end
            end
            S_ADJUST: begin
                if (w_in_band) begin
                    if (r_lock_cnt != L_LOCK) begin
                        w_lock_nxt = r_lock_cnt + 1'b1;
                    end
                    w_locked_nxt = (w_lock_nxt == L_LOCK);
                    w_state_nxt  = S_MEASURE;
                end else begin
                    w_lock_nxt   = '0;
                    w_locked_nxt = 1'b0;
                    w_sat_hi_nxt = w_clamp_hi;
                    w_sat_lo_nxt = w_clamp_lo;
                    w_gain_nxt   = w_gain_adj;
                    // Already pinned at a clamp: nothing moved, so no settle.
                    if (w_gain_adj != r_gain) begin
                        w_state_nxt  = S_SETTLE;
                        w_settle_nxt = '0;
                    end else begin
                        w_state_nxt = S_MEASURE;
                    end
                end
            end
            S_SETTLE: begin
                if (r_settle_cnt == L_SET_LAST) begin
                    w_state_nxt  = S_MEASURE;
                    w_settle_nxt = '0;
                end else begin
                    w_settle_nxt = r_settle_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Disable overrides the state only; a step decided in ADJUST still
        // lands on this edge and the saturation flags are kept.
        if (!i_en) begin
            w_state_nxt  = S_IDLE;
            w_locked_nxt = 1'b0;
            w_lock_nxt   = '0;
            w_settle_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_gain       <= GAIN_WIDTH'(GAIN_INIT);
            r_upd        <= 1'b0;
            r_locked     <= 1'b0;
            r_sat_hi     <= 1'b0;
            r_sat_lo     <= 1'b0;
            r_settle_cnt <= '0;
            r_lock_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_gain       <= w_gain_nxt;
            r_upd        <= (w_gain_nxt != r_gain);
            r_locked     <= w_locked_nxt;
            r_sat_hi     <= w_sat_hi_nxt;
            r_sat_lo     <= w_sat_lo_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_lock_cnt   <= w_lock_nxt;
        end
    end

    // Measurement capture register: pure data, no reset needed.
    always_ff @(posedge clk) begin
        if ((r_state == S_MEASURE) && i_pow_valid) begin
            r_pow <= i_pow_in;
        end
    end

    assign o_gain_out    = r_gain;
    assign o_gain_update = r_upd;
    assign o_locked      = r_locked;
    assign o_sat_hi      = r_sat_hi;
    assign o_sat_lo      = r_sat_lo;
    assign o_state_dbg   = r_state;

endmodule

// File: tb/tb_agc_gain_ctrl.sv
// ============================================================================
// tb_agc_gain_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for agc_gain_ctrl. A behavioural model tracks the loop
// with plain integer arithmetic and a settle deadline; a negedge compare
// process checks every output each cycle. Directed scenarios pin the model
// with literal expectations, then a randomized phase exercises the loop.
// ============================================================================
module tb_agc_gain_ctrl;

    localparam int PW     = 16;
    localparam int GW     = 8;
    localparam int G_INIT = 128;
    localparam int G_MIN  = 10;
    localparam int G_MAX  = 240;
    localparam int ST_C   = 8;
    localparam int ST_F   = 1;
    localparam int SETTLE = 64;
    localparam int LOCK   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          gain_load = 1'b0;
    logic [GW-1:0] gain_load_val = '0;
    logic [PW-1:0] pow_in = '0;
    logic          pow_valid = 1'b0;
    logic [PW-1:0] target = '0;
    logic [PW-1:0] tol = '0;

    logic [GW-1:0] gain_out;
    logic          gain_update, locked, sat_hi, sat_lo;
    logic [1:0]    state_dbg;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    agc_gain_ctrl #(
        .POW_WIDTH(PW), .GAIN_WIDTH(GW), .GAIN_INIT(G_INIT),
        .GAIN_MIN(G_MIN), .GAIN_MAX(G_MAX), .STEP_COARSE(ST_C),
        .STEP_FINE(ST_F), .SETTLE_CYCLES(SETTLE), .LOCK_COUNT(LOCK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_en(en), .i_gain_load(gain_load),
        .i_gain_load_val(gain_load_val), .i_pow_in(pow_in),
        .i_pow_valid(pow_valid), .i_target(target), .i_tol(tol),
        .o_gain_out(gain_out), .o_gain_update(gain_update),
        .o_locked(locked), .o_sat_hi(sat_hi), .o_sat_lo(sat_lo),
        .o_state_dbg(state_dbg)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Modes: 0 idle, 1 waiting for a sample, 2 evaluating, 3 settling.
    int m_state = 0, m_gain = G_INIT, m_upd = 0, m_locked = 0;
    int m_sat_hi = 0, m_sat_lo = 0, m_run = 0, m_pow = 0;
    int m_cyc = 0, m_settle_end = 0;

    function automatic int clampg(input int v);
        if (v < G_MIN) return G_MIN;
        if (v > G_MAX) return G_MAX;
        return v;
    endfunction

    task automatic model_reset();
        m_state = 0; m_gain = G_INIT; m_upd = 0; m_locked = 0;
        m_sat_hi = 0; m_sat_lo = 0; m_run = 0;
    endtask

    task automatic model_step();
        int nxt, g, err, mag, step, want;
        nxt = m_state;
        g   = m_gain;
        case (m_state)
            0: begin
                if (en) nxt = 1;
                else if (gain_load) g = clampg(int'(gain_load_val));
            end
            1: begin
                if (pow_valid) begin
                    m_pow = int'(pow_in);
                    nxt = 2;
                end
            end
            2: begin
                err = m_pow - int'(target);
                mag = (err < 0) ? -err : err;
                if (mag <= int'(tol)) begin
                    m_run = (m_run + 1 > LOCK) ? LOCK : m_run + 1;
                    m_locked = (m_run == LOCK) ? 1 : 0;
                    nxt = 1;
                end else begin
                    m_run = 0;
                    m_locked = 0;
                    step = (mag >= 4 * int'(tol)) ? ST_C : ST_F;
                    want = (err > 0) ? m_gain - step : m_gain + step;
                    m_sat_hi = (want > G_MAX) ? 1 : 0;
                    m_sat_lo = (want < G_MIN) ? 1 : 0;
                    g = clampg(want);
                    if (g != m_gain) begin
                        nxt = 3;
                        m_settle_end = m_cyc + SETTLE;
                    end else begin
                        nxt = 1;
                    end
                end
            end
            default: begin
                if (m_cyc == m_settle_end) nxt = 1;
            end
        endcase
        if (!en) begin
            nxt = 0;
            m_locked = 0;
            m_run = 0;
        end
        m_upd   = (g != m_gain) ? 1 : 0;
        m_gain  = g;
        m_state = nxt;
        m_cyc++;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            check("model gain_out",    int'(gain_out),    m_gain);
            check("model gain_update", int'(gain_update), m_upd);
            check("model locked",      int'(locked),      m_locked);
            check("model sat_hi",      int'(sat_hi),      m_sat_hi);
            check("model sat_lo",      int'(sat_lo),      m_sat_lo);
            check("model state_dbg",   int'(state_dbg),   m_state);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge while in MEASURE; returns at the negedge after the
    // evaluation edge, i.e. when the resulting gain is visible.
    task automatic sample(input int p);
        pow_in = PW'(p);
        pow_valid = 1'b1;
        @(negedge clk);
        pow_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_gain(input int v);
        en = 1'b0;
        tick(1);
        gain_load = 1'b1;
        gain_load_val = GW'(v);
        tick(1);
        gain_load = 1'b0;
        en = 1'b1;
        tick(1);
    endtask

    function automatic int pick_pow();
        int t, d, r, v;
        t = int'(target);
        d = int'(tol);
        r = int'($urandom_range(0, 5));
        case (r)
            0: v = t + int'($urandom_range(0, 2 * d)) - d;
            1: v = ($urandom_range(0, 1) == 0) ? t + d : t - d;
            2: v = ($urandom_range(0, 1) == 0) ? t + 4 * d : t - 4 * d;
            3: v = ($urandom_range(0, 1) == 0) ? t + 4 * d - 1 : t - 4 * d + 1;
            4: v = t + int'($urandom_range(0, 6000)) - 3000;
            default: v = ($urandom_range(0, 1) == 0) ? 0 : 65535;
        endcase
        if (v < 0) v = 0;
        if (v > 65535) v = 65535;
        return v;
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        @(posedge clk);
        #2;
        check("reset gain_out", int'(gain_out), 128);
        check("reset locked", int'(locked), 0);
        check("reset state", int'(state_dbg), 0);
        check("reset gain_update", int'(gain_update), 0);
        @(negedge clk);
        rst_n = 1'b1;
        target = PW'(1000);
        tol = PW'(50);
        en = 1'b1;
        tick(1);
        check("enter measure", int'(state_dbg), 1);

        // in-band samples build lock
        for (int k = 0; k < 4; k++) begin
            sample(1020);
            check("inband gain", int'(gain_out), 128);
            check("inband locked", int'(locked), (k == 3) ? 1 : 0);
            tick(SETTLE + 4);
        end

        // coarse step down, samples during settle ignored
        sample(2000);
        check("coarse gain", int'(gain_out), 120);
        check("coarse pulse", int'(gain_update), 1);
        check("coarse state", int'(state_dbg), 3);
        check("coarse unlock", int'(locked), 0);
        repeat (6) begin
            pow_in = PW'(2000);
            pow_valid = 1'b1;
            tick(1);
            pow_valid = 1'b0;
            tick(4);
        end
        check("settle hold gain", int'(gain_out), 120);
        check("settle state", int'(state_dbg), 3);
        tick(SETTLE);
        check("settle done", int'(state_dbg), 1);

        // fine step up from 128
        load_gain(128);
        check("load 128", int'(gain_out), 128);
        sample(900);
        check("fine gain", int'(gain_out), 129);
        check("fine pulse", int'(gain_update), 1);
        tick(SETTLE + 2);

        // saturate high
        load_gain(234);
        sample(0);
        check("sat_hi gain", int'(gain_out), 240);
        check("sat_hi flag", int'(sat_hi), 1);
        tick(SETTLE + 2);
        sample(0);
        check("clamped gain", int'(gain_out), 240);
        check("clamped no pulse", int'(gain_update), 0);
        check("clamped no settle", int'(state_dbg), 1);
        check("clamped sat_hi", int'(sat_hi), 1);

        // en dropped in SETTLE, then manual loads with clamping
        sample(2000);
        check("down from max", int'(gain_out), 232);
        check("sat_hi cleared", int'(sat_hi), 0);
        tick(5);
        en = 1'b0;
        tick(1);
        check("disable idle", int'(state_dbg), 0);
        check("disable gain held", int'(gain_out), 232);
        check("disable locked", int'(locked), 0);
        gain_load = 1'b1;
        gain_load_val = GW'(250);
        tick(1);
        check("load clamp max", int'(gain_out), 240);
        check("load clamp pulse", int'(gain_update), 1);
        gain_load_val = GW'(3);
        tick(1);
        check("load clamp min", int'(gain_out), 10);
        gain_load_val = GW'(10);
        tick(1);
        check("load same no pulse", int'(gain_update), 0);
        gain_load = 1'b0;
        en = 1'b1;
        tick(1);
        sample(2000);
        check("sat_lo gain", int'(gain_out), 10);
        check("sat_lo flag", int'(sat_lo), 1);
        check("sat_lo no pulse", int'(gain_update), 0);

        // zero tolerance
        load_gain(128);
        tol = '0;
        sample(1000);
        check("tol0 inband gain", int'(gain_out), 128);
        check("tol0 inband state", int'(state_dbg), 1);
        sample(1001);
        check("tol0 coarse gain", int'(gain_out), 120);
        check("tol0 sat_lo cleared", int'(sat_lo), 0);

        // asynchronous reset in the middle of SETTLE
        tick(10);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async rst gain", int'(gain_out), 128);
        check("async rst state", int'(state_dbg), 0);
        check("async rst locked", int'(locked), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);

        // randomized phase
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 299) == 0) en = ~en;
            if ((c % 500) == 0) begin
                target = PW'($urandom_range(0, 4000));
                tol = ($urandom_range(0, 4) == 0) ? '0 : PW'($urandom_range(1, 120));
            end
            gain_load = ($urandom_range(0, 3) == 0);
            gain_load_val = GW'($urandom_range(0, 255));
            pow_valid = ($urandom_range(0, 3) == 0);
            pow_in = PW'(pick_pow());
            tick(1);
        end
        pow_valid = 1'b0;
        gain_load = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
